// File: rtl/wb_burst_memory_if.sv
// Wishbone B3 bus bundle between a master and the wb_burst_memory slave.
interface wb_burst_memory_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_burst_memory.sv
// Wishbone B3 slave memory with classic cycles, incrementing/wrapping bursts and first-beat wait states.
// Define WB_BURST_MEMORY_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
module wb_burst_memory #(
  parameter int             DW          = 32,
  parameter int             AW          = 32,
  parameter int             MEM_BYTES   = 1024,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int             WAIT_STATES = 0
) (
  input logic              wb_clk_i,
  input logic              wb_rst_n_i,
  wb_burst_memory_if.slave wb
);

`ifdef WB_BURST_MEMORY_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int BPW   = DW / 8;
  localparam int BSH   = $clog2(BPW);
  localparam int DEPTH = MEM_BYTES / BPW;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] start_idx;
  logic [AW-1:0] off;
  logic          in_rng;
  logic [2:0]    cti_r;
  logic [1:0]    bte_r;
  logic          we_r;
  logic          oor_r;
  logic [3:0]    cnt;
  logic          ack;
  logic          err;
  logic [DW-1:0] dat;

  // Wrap modes only advance the low index bits; the block base stays put.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i, input logic [1:0] bte);
    logic [IW-1:0] m;
    logic [IW-1:0] inc;
    case (bte)
      2'b01:   m = IW'(3);
      2'b10:   m = IW'(7);
      2'b11:   m = IW'(15);
      default: m = '1;
    endcase
    inc = i + IW'(1);
    return ((i & ~m) | (inc & m)) & IW'(DEPTH - 1);
  endfunction

  assign off       = wb.wb_adr_i - BASE_ADDR;
  assign in_rng    = ({1'b0, off} < (AW + 1)'(MEM_BYTES));
  assign start_idx = IW'(off >> BSH) & IW'(DEPTH - 1);
  assign idx_nxt   = next_idx(idx, bte_r);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
      dat   <= '0;
      cnt   <= '0;
      idx   <= '0;
      cti_r <= '0;
      bte_r <= '0;
      we_r  <= 1'b0;
      oor_r <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        // A response already on the bus means the master is still showing the finished cycle.
        IDLE: if (wb.wb_cyc_i && wb.wb_stb_i && !ack && !err) begin
          idx   <= start_idx;
          cti_r <= wb.wb_cti_i;
          bte_r <= wb.wb_bte_i;
          we_r  <= wb.wb_we_i;
          oor_r <= ERR_EN && !in_rng;
          cnt   <= 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
          state <= (WAIT_STATES == 0) ? ACK : WAIT;
        end
        WAIT: begin
          if (!wb.wb_cyc_i)  state <= IDLE;
          else if (cnt == 0) state <= ACK;
          else               cnt   <= cnt - 4'd1;
        end
        ACK: begin
          if (!wb.wb_cyc_i) begin
            state <= IDLE;
          end else if (oor_r) begin
            err   <= 1'b1;
            dat   <= '0;
            state <= IDLE;
          end else begin
            ack <= 1'b1;
            if (!we_r) dat <= mem[idx];
            state <= (cti_r == 3'b010 && wb.wb_cti_i != 3'b111) ? BURST : IDLE;
          end
        end
        BURST: begin
          if (!wb.wb_cyc_i) begin
            state <= IDLE;
          end else if (wb.wb_stb_i) begin
            if (ERR_EN && bte_r == 2'b00 && idx == IW'(DEPTH - 1)) begin
              err   <= 1'b1;
              dat   <= '0;
              state <= IDLE;
            end else begin
              ack <= 1'b1;
              idx <= idx_nxt;
              if (!we_r) dat <= mem[idx_nxt];
              if (wb.wb_cti_i == 3'b111) state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Write data and lanes are taken from the ack cycle itself, committed at its closing edge.
  always_ff @(posedge wb_clk_i) begin
    if (ack && we_r) begin
      for (int b = 0; b < BPW; b++) begin
        if (wb.wb_sel_i[b]) mem[idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb.wb_dat_o = dat;
  assign wb.wb_ack_o = ack;
  assign wb.wb_err_o = ERR_EN & err;
  assign wb.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_memory.sv
// Self-checking bench for wb_burst_memory: vector table, directed burst/abort/reset sequences, random traffic.
module tb_wb_burst_memory;
  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int MEM_BYTES = 1024;
  localparam int WS        = 3;
  localparam int DEPTH     = MEM_BYTES / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_burst_memory_if #(.DW(DW), .AW(AW)) bus ();

  wb_burst_memory #(
    .DW(DW), .AW(AW), .MEM_BYTES(MEM_BYTES), .BASE_ADDR('0), .WAIT_STATES(WS)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb        (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] model [DEPTH];
  logic [31:0] bwr [256];
  logic [31:0] brd [256];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Word touched by beat k of a burst: linear walks the whole memory, wrap-N stays in its aligned N-word block.
  function automatic int beat_idx(input int start, input logic [1:0] bte, input int k);
    int w;
    w = (bte == 2'b00) ? DEPTH : (4 << (int'(bte) - 1));
    return (start / w) * w + ((start % w) + k) % w;
  endfunction

  task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output logic ok,
                         output logic er, output int lat);
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = we;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    lat = -1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.wb_ack_o && !bus.wb_err_o && lat < 40);
    ok = bus.wb_ack_o;
    er = bus.wb_err_o;
    rd = bus.wb_dat_o;
    check("ack_err_exclusive", {63'd0, bus.wb_ack_o & bus.wb_err_o}, 64'd0);
    @(posedge clk); #1;
    check("single_cycle_resp", {62'd0, bus.wb_ack_o, bus.wb_err_o}, 64'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    logic ok, er;
    int lat;
    classic(1'b1, adr, dat, sel, rd, ok, er, lat);
    check("wr_ack", {63'd0, ok}, 64'd1);
    check("wr_latency", 64'(lat), 64'(WS + 1));
    model[(adr % MEM_BYTES) / 4] = merge(model[(adr % MEM_BYTES) / 4], dat, sel);
  endtask

  task automatic do_rd(input logic [31:0] adr, output logic [31:0] rd);
    logic ok, er;
    int lat;
    classic(1'b0, adr, 32'h0, 4'hF, rd, ok, er, lat);
    check("rd_ack", {63'd0, ok}, 64'd1);
    check("rd_latency", 64'(lat), 64'(WS + 1));
  endtask

  // Pipelined master: stb/cti describe the beat served at the coming edge, write data follows each ack.
  task automatic burst(input logic we, input logic [31:0] adr, input logic [1:0] bte, input int n,
                       input int drop_after, input int drop_len);
    int acks, cyc_n, gaps, drop_rem, errs;
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_bte_i = bte;
    bus.wb_sel_i = 4'hF;
    bus.wb_cti_i = (n == 1) ? 3'b111 : 3'b010;
    bus.wb_dat_i = bwr[0];
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    acks = 0; cyc_n = 0; gaps = 0; drop_rem = 0; errs = 0;
    while (acks < n && cyc_n < 4000) begin
      @(posedge clk); #1;
      cyc_n++;
      if (bus.wb_err_o) errs++;
      if (bus.wb_ack_o) begin
        brd[acks]    = bus.wb_dat_o;
        bus.wb_dat_i = bwr[acks];
        acks++;
        if (acks == drop_after) drop_rem = drop_len;
      end else if (acks > 0) begin
        gaps++;
      end
      if (drop_rem > 0) begin
        bus.wb_stb_i = 1'b0;
        drop_rem--;
      end else begin
        bus.wb_stb_i = 1'b1;
      end
      bus.wb_cti_i = (acks == n - 1) ? 3'b111 : 3'b010;
    end
    check("burst_acks", 64'(acks), 64'(n));
    check("burst_gaps", 64'(gaps), (drop_after > 0 && drop_after < n) ? 64'(drop_len) : 64'd0);
    check("burst_no_err", 64'(errs), 64'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cti_i = 3'b000;
    @(posedge clk); #1;
    check("burst_end_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    bus.wb_we_i = 1'b0;
  endtask

  task automatic apply_burst_model(input logic we, input int start, input logic [1:0] bte, input int n);
    for (int k = 0; k < n; k++) begin
      if (we) model[beat_idx(start, bte, k)] = bwr[k];
      else    check("burst_rd_data", 64'(brd[k]), 64'(model[beat_idx(start, bte, k)]));
    end
  endtask

  initial begin
    vec_t        tbl [12];
    int          exp_idx [4];
    logic [31:0] rd;
    logic        ok, er;
    int          lat, seen;

    tbl[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[3]  = '{1'b1, 32'h20, 32'h00000012, 4'h1, 32'h0};
    tbl[4]  = '{1'b0, 32'h20, 32'h0,        4'hF, 32'hFFFFFF12};
    tbl[5]  = '{1'b1, 32'h24, 32'h11223344, 4'hF, 32'h0};
    tbl[6]  = '{1'b1, 32'h24, 32'hA5A5A5A5, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 32'h24, 32'h0,        4'hF, 32'h11223344};
    tbl[8]  = '{1'b1, 32'h28, 32'h00000000, 4'hF, 32'h0};
    tbl[9]  = '{1'b1, 32'h28, 32'hAABBCCDD, 4'hA, 32'h0};
    tbl[10] = '{1'b0, 32'h28, 32'h0,        4'hF, 32'hAA00CC00};
    tbl[11] = '{1'b0, 32'h2B, 32'h0,        4'hF, 32'hAA00CC00};
    exp_idx = '{14, 15, 12, 13};

    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    check("reset_err", {63'd0, bus.wb_err_o}, 64'd0);
    check("reset_rty", {63'd0, bus.wb_rty_o}, 64'd0);
    check("reset_dat", 64'(bus.wb_dat_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known contents everywhere via one long linear write burst.
    for (int k = 0; k < 256; k++) bwr[k] = $urandom;
    burst(1'b1, 32'h0, 2'b00, DEPTH, 0, 0);
    apply_burst_model(1'b1, 0, 2'b00, DEPTH);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we) begin
        do_wr(tbl[i].adr, tbl[i].dat, tbl[i].sel);
      end else begin
        do_rd(tbl[i].adr, rd);
        check($sformatf("table_rd_%0d", i), 64'(rd), 64'(tbl[i].exp));
      end
    end

    // Wrap4 read starting mid-block.
    burst(1'b0, 32'h38, 2'b01, 4, 0, 0);
    for (int k = 0; k < 4; k++) check("wrap4_order", 64'(brd[k]), 64'(model[exp_idx[k]]));

    // Linear write burst with a two-cycle master stall after the third beat.
    for (int k = 0; k < 8; k++) bwr[k] = 32'h5A000000 ^ (32'(k) * 32'h01010101);
    burst(1'b1, 32'h0, 2'b00, 8, 3, 2);
    apply_burst_model(1'b1, 0, 2'b00, 8);
    for (int k = 0; k < 8; k++) begin
      do_rd(32'(k * 4), rd);
      check("linear_wr_readback", 64'(rd), 64'(bwr[k]));
    end

    // Abandon a write while it waits out the wait states.
    bus.wb_adr_i = 32'h30; bus.wb_dat_i = 32'hCAFEF00D; bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b1;
    bus.wb_cti_i = 3'b000; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o || bus.wb_err_o) seen++;
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    do_rd(32'h30, rd);
    check("abort_no_write", 64'(rd), 64'(model[12]));

    // Reset in the middle of a read burst.
    bus.wb_adr_i = 32'h80; bus.wb_we_i = 1'b0; bus.wb_bte_i = 2'b00; bus.wb_cti_i = 3'b010;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.wb_ack_o && lat < 40);
    check("mid_reset_first_ack", {63'd0, bus.wb_ack_o}, 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    check("mid_reset_dat", 64'(bus.wb_dat_o), 64'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_rd(32'h80, rd);
    check("mem_kept_over_reset", 64'(rd), 64'(model[32]));
    do_rd(32'h84, rd);
    check("mem_kept_over_reset", 64'(rd), 64'(model[33]));

    // Address one past the top of memory.
    classic(1'b0, 32'h400, 32'h0, 4'hF, rd, ok, er, lat);
    check("oob_latency", 64'(lat), 64'(WS + 1));
`ifdef WB_BURST_MEMORY_ERR_EN
    check("oob_err", {62'd0, er, ok}, 64'd2);
    check("oob_dat", 64'(rd), 64'd0);
`else
    check("oob_alias_ack", {62'd0, er, ok}, 64'd1);
    check("oob_alias_dat", 64'(rd), 64'(model[0]));
`endif

    // Random traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      int kind, n, start, da, dl;
      logic [1:0] bte;
      logic [31:0] adr;
      kind = $urandom_range(0, 3);
      adr  = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      case (kind)
        0: do_wr(adr, $urandom, 4'($urandom_range(0, 15)));
        1: begin
          do_rd(adr, rd);
          check("rand_rd", 64'(rd), 64'(model[(adr % MEM_BYTES) / 4]));
        end
        default: begin
          bte   = 2'($urandom_range(0, 3));
          n     = $urandom_range(1, 12);
          start = $urandom_range(0, DEPTH - 13);
          da    = $urandom_range(0, n - 1);
          dl    = (da > 0) ? $urandom_range(1, 3) : 0;
          for (int k = 0; k < n; k++) bwr[k] = $urandom;
          burst(kind == 2, 32'(start * 4), bte, n, da, dl);
          apply_burst_model(kind == 2, start, bte, n);
        end
      endcase
    end

    check("rty_tied_low", {63'd0, bus.wb_rty_o}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
